// File: rtl/pif_neuron_sequencer.sv
// pif_neuron_sequencer
//   Timestep controller for a single PIF neuron. Each timestep it takes one
//   input spike vector and walks it bit by bit. For every set bit it issues a
//   weight-memory read. The weights come back MEM_LATENCY cycles later and are
//   streamed to the neuron on weightData. It then strobes updateEnable and
//   captures the neuron's spike.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   start                   begin an inference (honoured only when idle)
//   spikeIn/Valid/Ready     input spike vector handshake; Ready pulses on consume
//   memEnable/memAddr       weight read strobe and address (= input index)
//   memData                 weight read data, MEM_LATENCY cycles after memEnable
//   weightData              returning weight to the neuron, 0 when nothing returns
//   neuronClear             one-cycle vmem clear at inference start
//   updateEnable            one-cycle neuron update strobe
//   spikeBuffer             neuron spike output
//   spikeOut/spikeOutValid  captured spike and its one-cycle valid pulse
//   timestep                current timestep index
//   busy, done              activity flag and end-of-inference pulse
module pif_neuron_sequencer #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_INPUT     = 64,
  parameter int ADDR_WIDTH    = 6,
  parameter int MEM_LATENCY   = 1,
  parameter int NUM_TIMESTEPS = 16,
  parameter int TS_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_INPUT-1:0]  spikeIn,
  input  logic                  spikeInValid,
  output logic                  spikeInReady,
  output logic                  memEnable,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [DATA_WIDTH-1:0] weightData,
  output logic                  neuronClear,
  output logic                  updateEnable,
  input  logic                  spikeBuffer,
  output logic                  spikeOut,
  output logic                  spikeOutValid,
  output logic [TS_WIDTH-1:0]   timestep,
  output logic                  busy,
  output logic                  done
);

  localparam int DW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_IN, S_SCAN, S_DRAIN, S_UPDATE, S_SAMPLE, S_DONE
  } state_t;

  state_t                  state, nxt;
  logic [NUM_INPUT-1:0]    spk_q;
  logic [NUM_INPUT-1:0]    spk_sh;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DW-1:0]           drain_cnt;
  logic [MEM_LATENCY-1:0]  vld_pipe;
  logic [TS_WIDTH-1:0]     ts_q;
  logic                    spike_q;
  logic                    cur_bit;
  logic                    last_ptr;
  logic                    last_drain;
  logic                    last_ts;

  // Shift rather than index so the pointer width never has to match the vector.
  assign spk_sh     = spk_q >> ptr;
  assign cur_bit    = spk_sh[0];
  assign last_ptr   = (ptr == ADDR_WIDTH'(NUM_INPUT - 1));
  assign last_drain = (drain_cnt == DW'(MEM_LATENCY - 1));
  assign last_ts    = (ts_q == TS_WIDTH'(NUM_TIMESTEPS - 1));

  always_comb begin
    nxt           = state;
    spikeInReady  = 1'b0;
    memEnable     = 1'b0;
    neuronClear   = 1'b0;
    updateEnable  = 1'b0;
    spikeOutValid = 1'b0;
    done          = 1'b0;
    case (state)
      S_IDLE:    if (start) nxt = S_CLEAR;
      S_CLEAR: begin
        neuronClear = 1'b1;
        nxt         = S_WAIT_IN;
      end
      S_WAIT_IN: if (spikeInValid) begin
        spikeInReady = 1'b1;
        nxt          = S_SCAN;
      end
      S_SCAN: begin
        memEnable = cur_bit;
        if (last_ptr) nxt = S_DRAIN;
      end
      S_DRAIN:   if (last_drain) nxt = S_UPDATE;
      S_UPDATE: begin
        updateEnable = 1'b1;
        nxt          = S_SAMPLE;
      end
      S_SAMPLE: begin
        spikeOutValid = 1'b1;
        nxt           = last_ts ? S_DONE : S_WAIT_IN;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      spk_q     <= '0;
      ptr       <= '0;
      addr_q    <= '0;
      drain_cnt <= '0;
      vld_pipe  <= '0;
      ts_q      <= '0;
      spike_q   <= 1'b0;
    end else begin
      state <= nxt;
      // Read-return tracker runs in every state so late returns land in DRAIN.
      vld_pipe[0] <= memEnable;
      for (int i = 1; i < MEM_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      case (state)
        S_CLEAR: begin
          ts_q    <= '0;
          spike_q <= 1'b0;
        end
        S_WAIT_IN: if (spikeInValid) begin
          spk_q <= spikeIn;
          ptr   <= '0;
        end
        S_SCAN: begin
          ptr       <= ptr + 1'b1;
          drain_cnt <= '0;
          if (memEnable) addr_q <= ptr;
        end
        S_DRAIN: drain_cnt <= drain_cnt + 1'b1;
        S_SAMPLE: begin
          spike_q <= spikeBuffer;
          if (!last_ts) ts_q <= ts_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // memAddr shows the live pointer on a read and otherwise holds the last read address.
  assign memAddr    = memEnable ? ptr : addr_q;
  assign weightData = (vld_pipe[MEM_LATENCY-1] && state != S_UPDATE) ? memData : '0;
  // The captured spike is presented in the same cycle as its valid pulse.
  assign spikeOut   = (state == S_SAMPLE) ? spikeBuffer : spike_q;
  assign timestep   = ts_q;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_pif_neuron_sequencer.sv
// Bench for pif_neuron_sequencer: directed steps, with a scoreboard of expected
// reads, weights and samples consumed by a negedge monitor.
module tb_pif_neuron_sequencer;
  localparam int N  = 8;
  localparam int L  = 2;
  localparam int T  = 3;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N-1:0]  spikeIn;
  logic          spikeInValid;
  logic          spikeInReady;
  logic          memEnable;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData;
  logic [DW-1:0] weightData;
  logic          neuronClear;
  logic          updateEnable;
  logic          spikeBuffer;
  logic          spikeOut;
  logic          spikeOutValid;
  logic [TW-1:0] timestep;
  logic          busy;
  logic          done;

  pif_neuron_sequencer #(
    .DATA_WIDTH(DW), .NUM_INPUT(N), .ADDR_WIDTH(AW),
    .MEM_LATENCY(L), .NUM_TIMESTEPS(T), .TS_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .spikeIn(spikeIn), .spikeInValid(spikeInValid), .spikeInReady(spikeInReady),
    .memEnable(memEnable), .memAddr(memAddr), .memData(memData),
    .weightData(weightData), .neuronClear(neuronClear), .updateEnable(updateEnable),
    .spikeBuffer(spikeBuffer), .spikeOut(spikeOut), .spikeOutValid(spikeOutValid),
    .timestep(timestep), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory: data = addr + 100, two-cycle latency, junk when not reading.
  logic [DW-1:0] md1 = 16'hDEAD;
  logic [DW-1:0] md2 = 16'hDEAD;
  always @(posedge clk) begin
    md1 <= memEnable ? ({{(DW-AW){1'b0}}, memAddr} + 16'd100) : 16'hDEAD;
    md2 <= md1;
  end
  assign memData = md2;

  int total = 0;
  int bad   = 0;
  int exp_addr[$];
  int exp_w[$];
  int rd_cyc[$];
  int exp_samp[$];
  int n_rdy = 0, n_upd = 0, n_sov = 0, n_done = 0, n_clr = 0;
  int last_rdy = 0, last_upd = 0, last_sov = 0;
  int mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] outs();
    return {1'b0, spikeInReady, memEnable, memAddr, weightData, neuronClear,
            updateEnable, spikeOut, spikeOutValid, timestep, busy, done};
  endfunction

  always @(negedge clk) if (!reset) begin
    if (memEnable) begin
      rd_cyc.push_back(cyc);
      if (exp_addr.size() == 0) chk("spurious_rd", 32'(memAddr), 32'hFFFF_FFFF);
      else chk("rd_addr", 32'(memAddr), 32'(exp_addr.pop_front()));
    end
    if (weightData != '0) begin
      if (exp_w.size() == 0) chk("spurious_wd", 32'(weightData), 0);
      else begin
        chk("wdata", 32'(weightData), 32'(exp_w.pop_front()));
        if (rd_cyc.size() > 0) chk("wd_lat", 32'(cyc - rd_cyc.pop_front()), L);
      end
    end
    if (spikeInReady) begin n_rdy++; last_rdy = cyc; end
    if (updateEnable) begin
      n_upd++; last_upd = cyc;
      chk("upd_wd0", 32'(weightData), 0);
    end
    if (spikeOutValid) begin
      n_sov++; last_sov = cyc;
      if (exp_samp.size() == 0) chk("spurious_sov", 1, 0);
      else begin
        mon_e = exp_samp.pop_front();
        chk("samp_ts", 32'(timestep), 32'(mon_e >> 1));
        chk("samp_spk", 32'(spikeOut), 32'(mon_e & 1));
      end
    end
    if (done) n_done++;
    if (neuronClear) n_clr++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int get_cnt(input int w);
    case (w)
      0: return n_rdy;
      1: return n_upd;
      2: return n_sov;
      3: return n_done;
      default: return 0;
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int w, input int target, input int limit);
    int k = 0;
    while (get_cnt(w) < target && k < limit) begin @(posedge clk); k++; end
    #1;
    if (get_cnt(w) < target) chk({tag, "_timeout"}, 32'(get_cnt(w)), 32'(target));
  endtask

  task automatic push_vec(input logic [N-1:0] v, input int ts, input logic sb);
    for (int i = 0; i < N; i++) if (v[i]) begin
      exp_addr.push_back(i);
      exp_w.push_back(i + 100);
    end
    exp_samp.push_back(ts * 2 + int'(sb));
  endtask

  task automatic start_inf();
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    chk("clr_pulse", 32'(neuronClear), 1);
    @(negedge clk);
    chk("wait_ts0", 32'(timestep), 0);
    chk("wait_busy", 32'(busy), 1);
    tick();
  endtask

  task automatic issue(input logic [N-1:0] v, input int ts, input logic sb);
    int r;
    r = n_rdy;
    push_vec(v, ts, sb);
    spikeIn = v; spikeBuffer = sb; spikeInValid = 1'b1;
    wait_cnt("rdy", 0, r + 1, 100);
    spikeInValid = 1'b0;
    spikeIn = N'($urandom);  // must be ignored from here on
  endtask

  task automatic finish_step();
    int s;
    s = n_sov;
    wait_cnt("sov", 2, s + 1, 100);
    chk("lat_upd", 32'(last_upd - last_rdy), N + L + 1);
    chk("lat_sov", 32'(last_sov - last_rdy), N + L + 2);
  endtask

  initial begin
    int c, r, u, s, d, k;
    reset = 1'b1; start = 1'b0; spikeIn = '0; spikeInValid = 1'b0; spikeBuffer = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", outs(), 0);
    @(posedge clk); #1 reset = 1'b0;
    tick();
    chk("idle_outs", outs(), 0);

    // Sparse vector, with a start pulse while busy that must be ignored.
    start_inf();
    issue(8'b1000_0101, 0, 1'b0);
    c = n_clr;
    start = 1'b1; tick(); start = 1'b0;
    finish_step();
    chk("start_ignored", 32'(n_clr), 32'(c));
    chk("busy_mid", 32'(busy), 1);

    // No input for 20 cycles: FSM must sit in WAIT_IN.
    u = n_upd; r = n_rdy;
    repeat (20) tick();
    chk("hold_upd", 32'(n_upd), 32'(u));
    chk("hold_rdy", 32'(n_rdy), 32'(r));
    chk("hold_busy", 32'(busy), 1);
    chk("hold_ts", 32'(timestep), 1);

    // All-zero vector, neuron spikes.
    issue('0, 1, 1'b1);
    chk("spk_hold0", 32'(spikeOut), 0);
    finish_step();
    tick();
    chk("spk_hold1", 32'(spikeOut), 1);

    // All-ones vector on the last timestep.
    d = n_done;
    issue('1, 2, 1'b0);
    chk("spk_hold2", 32'(spikeOut), 1);
    finish_step();
    wait_cnt("done", 3, d + 1, 20);
    chk("done_ts", 32'(timestep), T - 1);
    chk("done_idle", 32'(busy), 0);
    chk("done_spk", 32'(spikeOut), 0);

    // Full inference with spikeInValid held high.
    d = n_done; r = n_rdy; u = n_upd; s = n_sov;
    start_inf();
    for (int t = 0; t < T; t++) push_vec(8'h3C, t, 1'b1);
    spikeIn = 8'h3C; spikeBuffer = 1'b1; spikeInValid = 1'b1;
    wait_cnt("done4", 3, d + 1, 200);
    spikeInValid = 1'b0;
    chk("t4_rdy", 32'(n_rdy - r), T);
    chk("t4_upd", 32'(n_upd - u), T);
    chk("t4_sov", 32'(n_sov - s), T);
    tick(); tick();
    chk("t4_done_once", 32'(n_done - d), 1);

    // Reset in the middle of a scan, with reads in flight.
    start_inf();
    r = n_rdy;
    push_vec('1, 0, 1'b0);
    spikeIn = '1; spikeInValid = 1'b1;
    wait_cnt("rdy1", 0, r + 1, 50);
    spikeInValid = 1'b0;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (memEnable && memAddr == AW'(5)) break;
      k++;
    end
    if (k >= 50) chk("ptr5_timeout", 32'(k), 0);
    #2 reset = 1'b1;
    #1 chk("rst_mid_outs", outs(), 0);
    exp_addr.delete(); exp_w.delete(); rd_cyc.delete(); exp_samp.delete();
    @(negedge clk);
    chk("rst_next_outs", outs(), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_outs", outs(), 0);
    tick();
    start_inf();
    issue(8'h01, 0, 1'b0);
    finish_step();

    chk("sb_empty", 32'(exp_addr.size() + exp_w.size() + exp_samp.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
